imem_loader: RTL

Boot controller that sequences the single-cycle-fetch core and configures its instruction memory.
- Holds the core in reset.
- Accepts a program as a valid/ready stream of 32-bit words and writes them into the 4096-word instruction RAM.
- Verifies a trailing 32-bit additive checksum.
- On a checksum match, releases the core so it starts fetching at word address 0.

---
 rtl/imem_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot controller: holds the core in reset, streams a program into instruction RAM,
// verifies a trailing additive checksum and releases the core on a match.
module imem_loader #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   load_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_RUN, S_ERROR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                s_ready_q, s_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                beat_s;
  logic                len_ok_s;

  assign beat_s   = s_valid & s_ready_q;
  assign len_ok_s = (load_len != {(ADDR_W+1){1'b0}}) && (load_len <= MAX_LEN);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sum_d        = sum_q;
    idle_d       = idle_q;
    word_count_d = word_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    err_code_d   = err_code_q;
    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          err_code_d = 2'd0;
          if (len_ok_s) begin
            state_d      = S_LOAD;
            len_d        = load_len;
            sum_d        = {DATA_W{1'b0}};
            idle_d       = {IDLE_W{1'b0}};
            word_count_d = {(ADDR_W+1){1'b0}};
          end else begin
            state_d    = S_ERROR;
            err_code_d = 2'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD, S_CHECK: begin
        // abort outranks a same-cycle beat, which outranks the timeout
        if (abort) begin
          state_d    = S_IDLE;
          err_code_d = 2'd0;
        end else if (beat_s) begin
          idle_d = {IDLE_W{1'b0}};
          if (state_q == S_LOAD) begin
            mem_we_d     = 1'b1;
            mem_addr_d   = word_count_q[ADDR_W-1:0];
            mem_wdata_d  = s_data;
            sum_d        = sum_q + s_data;
            word_count_d = word_count_q + {{ADDR_W{1'b0}}, 1'b1};
            if (word_count_d == len_q) begin
              state_d = S_CHECK;
            end else begin
              state_d = S_LOAD;
            end
          end else if (s_data == sum_q) begin
            state_d = S_RUN;
          end else begin
            state_d    = S_ERROR;
            err_code_d = 2'd2;
          end
        end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
          state_d    = S_ERROR;
          err_code_d = 2'd3;
        end else begin
          idle_d = idle_q + {{(IDLE_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    s_ready_d    = (state_d == S_LOAD) || (state_d == S_CHECK);
    busy_d       = s_ready_d;
    core_rst_n_d = (state_d == S_RUN);
    done_d       = (state_d == S_RUN);
    err_d        = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= {(ADDR_W+1){1'b0}};
      sum_q        <= {DATA_W{1'b0}};
      idle_q       <= {IDLE_W{1'b0}};
      word_count_q <= {(ADDR_W+1){1'b0}};
      s_ready_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sum_q        <= sum_d;
      idle_q       <= idle_d;
      word_count_q <= word_count_d;
      s_ready_q    <= s_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign word_count = word_count_q;

endmodule
